edp_fm_12to17: RTL

Fast-memory (AC file) slice for data bits 12-17, directly upstream of the EDP 12-17 slice. It holds 8 blocks x 16 ACs x (6 data + 1 parity) and is written from AR 12-17 under the CON FM write strobe. It delivers registered read data and stored parity to the EDP AD-A path and FM parity net. An internal sequencer initialises the array after reset and after a re-init request. It also checks and logs read parity errors.

---
 rtl/edp_fm_pkg.sv | 28 ++
 rtl/edp_fm_12to17_if.sv | 34 +++
 rtl/edp_fm_ram.sv | 27 ++
 rtl/edp_fm_12to17.sv | 117 +++++++++++
 4 files changed

// File: rtl/edp_fm_pkg.sv
// Shared types for the FM (AC file) slice covering data bits 12-17.
// Holds the word layout, sequencer states and the parity helper.
package edp_fm_pkg;

    localparam int DATA_W = 6;
    localparam int BLOCKS = 8;
    localparam int ACS    = 16;
    localparam int IDX_W  = $clog2(BLOCKS) + $clog2(ACS);
    localparam int WORDS  = BLOCKS * ACS;

    typedef logic [IDX_W-1:0] fm_idx_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              par;
    } fm_word_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fm_state_e;

    // Bit that makes the total number of ones across data and parity odd.
    function automatic logic odd_par(input logic [DATA_W-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/edp_fm_12to17_if.sv
// Bus bundle between the APR/CON/AR sources and the FM 12-17 slice.
// The master side drives the index and write controls; the slave side is the FM.
interface edp_fm_12to17_if;

    logic [2:0] apr_fm_block_h;
    logic [3:0] apr_fm_adr_h;
    logic       con_fm_write_00to17_l;
    logic [5:0] ar_12to17_h;
    logic       diag_force_bad_par_h;
    logic       fm_reinit_h;
    logic       fm_par_err_clr_h;

    logic [5:0] fm_12to17_h;
    logic       edp_fm_parity_12to17_h;
    logic       fm_par_err_h;
    logic       fm_par_err_sticky_h;
    logic [6:0] fm_par_err_adr_h;
    logic       fm_busy_h;

    modport master (
        output apr_fm_block_h, apr_fm_adr_h, con_fm_write_00to17_l, ar_12to17_h,
               diag_force_bad_par_h, fm_reinit_h, fm_par_err_clr_h,
        input  fm_12to17_h, edp_fm_parity_12to17_h, fm_par_err_h,
               fm_par_err_sticky_h, fm_par_err_adr_h, fm_busy_h
    );

    modport slave (
        input  apr_fm_block_h, apr_fm_adr_h, con_fm_write_00to17_l, ar_12to17_h,
               diag_force_bad_par_h, fm_reinit_h, fm_par_err_clr_h,
        output fm_12to17_h, edp_fm_parity_12to17_h, fm_par_err_h,
               fm_par_err_sticky_h, fm_par_err_adr_h, fm_busy_h
    );

endinterface

// File: rtl/edp_fm_ram.sv
// 128 x 7 synchronous single-port word array with write-first read port.
// Contents are never reset; the sequencer in the parent initialises them.
module edp_fm_ram
    import edp_fm_pkg::*;
(
    input  logic     clk_h,
    input  logic     we,
    input  fm_idx_t  idx,
    input  fm_word_t wdata,
    output fm_word_t rdata
);

    fm_word_t mem_q [WORDS];
    fm_word_t rdata_q;

    always_ff @(posedge clk_h) begin
        if (we) begin
            mem_q[idx] <= wdata;
            rdata_q    <= wdata;
        end else begin
            rdata_q    <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/edp_fm_12to17.sv
// FM slice for bits 12-17: init sequencer, write path, registered read,
// one-cycle-late parity checker and sticky error log.
module edp_fm_12to17
    import edp_fm_pkg::*;
(
    input  logic clk_h,
    input  logic reset_h,
    edp_fm_12to17_if.slave fm
);

    fm_state_e state_q, state_d;
    fm_idx_t   cnt_q, cnt_d;
    logic      rd_vld_q, rd_vld_d;
    fm_idx_t   rd_idx_q, rd_idx_d;
    logic      err_q, err_d;
    logic      sticky_q, sticky_d;
    fm_idx_t   err_adr_q, err_adr_d;

    logic      ram_we;
    fm_idx_t   ram_idx;
    fm_word_t  ram_wdata;
    fm_word_t  ram_rdata;
    fm_idx_t   ext_idx;

    assign ext_idx = {fm.apr_fm_block_h, fm.apr_fm_adr_h};

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rd_vld_d       = 1'b0;
        rd_idx_d       = ext_idx;
        ram_we         = 1'b0;
        ram_idx        = ext_idx;
        ram_wdata.data = fm.ar_12to17_h;
        ram_wdata.par  = odd_par(fm.ar_12to17_h) ^ fm.diag_force_bad_par_h;

        case (state_q)
            INIT: begin
                ram_we         = 1'b1;
                ram_idx        = cnt_q;
                ram_wdata.data = '0;
                ram_wdata.par  = 1'b1;
                if (fm.fm_reinit_h) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q == fm_idx_t'(WORDS - 1)) state_d = RUN;
                end
            end
            RUN: begin
                if (fm.fm_reinit_h) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else begin
                    ram_we   = ~fm.con_fm_write_00to17_l;
                    rd_vld_d = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase

        // No array writes on a reset edge; the following INIT pass owns the array.
        if (reset_h) ram_we = 1'b0;

        // Checker looks at the word the read outputs have shown for one cycle.
        err_d = rd_vld_q & ~(^{ram_rdata.data, ram_rdata.par});

        sticky_d  = sticky_q;
        err_adr_d = err_adr_q;
        if (err_d) begin
            sticky_d = 1'b1;
            if (!sticky_q || fm.fm_par_err_clr_h) err_adr_d = rd_idx_q;
        end else if (fm.fm_par_err_clr_h) begin
            sticky_d  = 1'b0;
            err_adr_d = '0;
        end
    end

    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            rd_vld_q  <= 1'b0;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_vld_q  <= rd_vld_d;
            err_q     <= err_d;
            sticky_q  <= sticky_d;
            err_adr_q <= err_adr_d;
        end
    end

    always_ff @(posedge clk_h) begin
        rd_idx_q <= rd_idx_d;
    end

    edp_fm_ram u_ram (
        .clk_h (clk_h),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Until a RUN-cycle read has landed, present the initialised word.
    assign fm.fm_12to17_h            = rd_vld_q ? ram_rdata.data : '0;
    assign fm.edp_fm_parity_12to17_h = rd_vld_q ? ram_rdata.par  : 1'b1;
    assign fm.fm_par_err_h           = err_q;
    assign fm.fm_par_err_sticky_h    = sticky_q;
    assign fm.fm_par_err_adr_h       = err_adr_q;
    assign fm.fm_busy_h              = (state_q == INIT);

endmodule
